// File: rtl/control_unit.sv
// control_unit: multi-cycle micro-step sequencer that drives every datapath control strobe
module control_unit #(
    parameter int MAX_STEP = 7
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] ir,
    input  logic        mem_rdy,
    output logic [15:0] reg_in,
    output logic [15:0] reg_out,
    output logic        PC_in,
    output logic        Inc_PC,
    output logic        IR_in,
    output logic        Y_in,
    output logic        Z_in,
    output logic        HI_in,
    output logic        LO_in,
    output logic        MAR_in,
    output logic        MDR_in,
    output logic        read,
    output logic        write,
    output logic        PCout,
    output logic        ZLOWout,
    output logic        ZHIout,
    output logic        LOout,
    output logic        HIout,
    output logic        MDRout,
    output logic        inPortout,
    output logic        Cout,
    output logic [4:0]  ALU_select,
    output logic        run,
    output logic        illegal_op
);
    typedef enum logic [$clog2(MAX_STEP+1)-1:0] {T0, T1, T2, T3, T4, T5, T6, T7} step_t;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SHL  = 5'b01000;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_IN   = 5'b10110;
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    step_t       step_q, step_d, last_step;
    logic        halted_q, halted_d;
    logic [4:0]  op;
    logic [15:0] ra_oh, rb_oh, rc_oh;
    logic        is_alu, is_addr, is_ld, is_st, is_md, legal, mem_wait;
    logic        unused_ir;

    assign op        = ir[31:27];
    assign ra_oh     = 16'd1 << ir[26:23];
    assign rb_oh     = 16'd1 << ir[22:19];
    assign rc_oh     = 16'd1 << ir[18:15];
    assign unused_ir = ^ir[14:0];
    assign is_alu    = op >= OP_ADD && op <= OP_SHL;
    assign is_ld     = op == OP_LD;
    assign is_st     = op == OP_ST;
    assign is_addr   = op == OP_ADDI || is_ld || is_st;
    assign is_md     = op == OP_MUL || op == OP_DIV;
    assign legal     = op <= OP_SHL || op == OP_ADDI || is_md || op == OP_JR || op == OP_IN ||
                       op == OP_MFHI || op == OP_MFLO || op == OP_NOP || op == OP_HALT;
    assign run       = !clr && !halted_q;

    // Sequencing: last execute step per instruction class, memory steps stall until mem_rdy
    always_comb begin
        last_step = (is_ld || is_st) ? T7 : is_md ? T6 : (is_alu || op == OP_ADDI) ? T5 : T3;
        mem_wait  = !mem_rdy && (step_q == T1 || (step_q == T6 && is_ld) || (step_q == T7 && is_st));
        step_d    = clr ? T0 : (halted_q || mem_wait) ? step_q :
                    step_q == last_step ? T0 : step_t'(step_q + 1'b1);
        halted_d  = !clr && (halted_q || (step_q == T3 && op == OP_HALT));
    end

    // Step and halt state, cleared synchronously by clr
    always_ff @(posedge clk) begin
        step_q   <= step_d;
        halted_q <= halted_d;
    end

    // Strobe decode from step and opcode; everything is silenced while clr is high or halted
    always_comb begin
        reg_in     = '0;
        reg_out    = '0;
        {PC_in, Inc_PC, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in, read, write} = '0;
        {PCout, ZLOWout, ZHIout, LOout, HIout, MDRout, inPortout, Cout} = '0;
        ALU_select = '0;
        illegal_op = 1'b0;
        if (run) begin
            case (step_q)
                T0: {PCout, MAR_in, Inc_PC} = 3'b111;
                T1: {read, MDR_in} = 2'b11;
                T2: {MDRout, IR_in} = 2'b11;
                T3: begin
                    reg_out    = (is_alu || is_addr) ? rb_oh : (is_md || op == OP_JR) ? ra_oh : '0;
                    Y_in       = is_alu || is_addr || is_md;
                    PC_in      = op == OP_JR;
                    Cout       = op == OP_LDI;
                    HIout      = op == OP_MFHI;
                    LOout      = op == OP_MFLO;
                    inPortout  = op == OP_IN;
                    reg_in     = (Cout || HIout || LOout || inPortout) ? ra_oh : '0;
                    illegal_op = !legal;
                end
                T4: begin
                    reg_out    = is_alu ? rc_oh : is_md ? rb_oh : '0;
                    Cout       = is_addr;
                    Z_in       = is_alu || is_addr || is_md;
                    ALU_select = (is_alu || is_md) ? op : is_addr ? OP_ADD : '0;
                end
                T5: begin
                    ZLOWout = is_alu || is_addr || is_md;
                    reg_in  = (is_alu || op == OP_ADDI) ? ra_oh : '0;
                    MAR_in  = is_ld || is_st;
                    LO_in   = is_md;
                end
                T6: begin
                    read    = is_ld;
                    MDR_in  = is_ld || is_st;
                    reg_out = is_st ? ra_oh : '0;
                    ZHIout  = is_md;
                    HI_in   = is_md;
                end
                T7: begin
                    MDRout = is_ld;
                    reg_in = is_ld ? ra_oh : '0;
                    write  = is_st;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: randomized check of control_unit against a micro-step table model
module tb_control_unit;
    typedef struct packed {
        logic [15:0] rin, rout;
        logic pc_in, inc_pc, ir_in, y_in, z_in, hi_in, lo_in, mar_in, mdr_in, rd, wr;
        logic pc_out, zlo_out, zhi_out, lo_out, hi_out, mdr_out, inp_out, c_out;
        logic [4:0] alu;
        logic run, ill;
    } ctl_t;

    logic clk = 0, clr = 1, mem_rdy = 0;
    logic [31:0] ir = 0;
    logic [15:0] reg_in, reg_out;
    logic PC_in, Inc_PC, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in, read, write;
    logic PCout, ZLOWout, ZHIout, LOout, HIout, MDRout, inPortout, Cout, run, illegal_op;
    logic [4:0] ALU_select;
    ctl_t obs;
    ctl_t steps[$];
    bit   mem[$];
    int   n_tests = 0, n_fail = 0;

    control_unit dut (
        .clk(clk), .clr(clr), .ir(ir), .mem_rdy(mem_rdy), .reg_in(reg_in), .reg_out(reg_out),
        .PC_in(PC_in), .Inc_PC(Inc_PC), .IR_in(IR_in), .Y_in(Y_in), .Z_in(Z_in), .HI_in(HI_in),
        .LO_in(LO_in), .MAR_in(MAR_in), .MDR_in(MDR_in), .read(read), .write(write),
        .PCout(PCout), .ZLOWout(ZLOWout), .ZHIout(ZHIout), .LOout(LOout), .HIout(HIout),
        .MDRout(MDRout), .inPortout(inPortout), .Cout(Cout), .ALU_select(ALU_select),
        .run(run), .illegal_op(illegal_op)
    );

    assign obs = {reg_in, reg_out, PC_in, Inc_PC, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in,
                  read, write, PCout, ZLOWout, ZHIout, LOout, HIout, MDRout, inPortout, Cout,
                  ALU_select, run, illegal_op};

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic ctl_t nul();
        ctl_t s = '0;
        s.run = 1'b1;
        return s;
    endfunction

    function automatic void push(input ctl_t s, input bit m);
        steps.push_back(s);
        mem.push_back(m);
    endfunction

    // Expected strobes for every micro-step of one instruction, straight from the opcode table
    function automatic void build(input logic [31:0] i);
        ctl_t s;
        logic [4:0]  op = i[31:27];
        logic [15:0] ra = 16'd1 << i[26:23];
        logic [15:0] rb = 16'd1 << i[22:19];
        logic [15:0] rc = 16'd1 << i[18:15];
        steps.delete();
        mem.delete();
        s = nul(); s.pc_out = 1; s.mar_in = 1; s.inc_pc = 1; push(s, 0);
        s = nul(); s.rd = 1; s.mdr_in = 1; push(s, 1);
        s = nul(); s.mdr_out = 1; s.ir_in = 1; push(s, 0);
        case (op)
            5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8: begin
                s = nul(); s.rout = rb; s.y_in = 1; push(s, 0);
                s = nul(); s.rout = rc; s.alu = op; s.z_in = 1; push(s, 0);
                s = nul(); s.zlo_out = 1; s.rin = ra; push(s, 0);
            end
            5'd12, 5'd0, 5'd2: begin
                s = nul(); s.rout = rb; s.y_in = 1; push(s, 0);
                s = nul(); s.c_out = 1; s.alu = 5'd3; s.z_in = 1; push(s, 0);
                if (op == 5'd12) begin
                    s = nul(); s.zlo_out = 1; s.rin = ra; push(s, 0);
                end else begin
                    s = nul(); s.zlo_out = 1; s.mar_in = 1; push(s, 0);
                    if (op == 5'd0) begin
                        s = nul(); s.rd = 1; s.mdr_in = 1; push(s, 1);
                        s = nul(); s.mdr_out = 1; s.rin = ra; push(s, 0);
                    end else begin
                        s = nul(); s.rout = ra; s.mdr_in = 1; push(s, 0);
                        s = nul(); s.wr = 1; push(s, 1);
                    end
                end
            end
            5'd15, 5'd16: begin
                s = nul(); s.rout = ra; s.y_in = 1; push(s, 0);
                s = nul(); s.rout = rb; s.alu = op; s.z_in = 1; push(s, 0);
                s = nul(); s.zlo_out = 1; s.lo_in = 1; push(s, 0);
                s = nul(); s.zhi_out = 1; s.hi_in = 1; push(s, 0);
            end
            5'd1:  begin s = nul(); s.c_out = 1; s.rin = ra; push(s, 0); end
            5'd24: begin s = nul(); s.hi_out = 1; s.rin = ra; push(s, 0); end
            5'd25: begin s = nul(); s.lo_out = 1; s.rin = ra; push(s, 0); end
            5'd22: begin s = nul(); s.inp_out = 1; s.rin = ra; push(s, 0); end
            5'd20: begin s = nul(); s.rout = ra; s.pc_in = 1; push(s, 0); end
            5'd26, 5'd27: push(nul(), 0);
            default: begin s = nul(); s.ill = 1; push(s, 0); end
        endcase
    endfunction

    // Run the first 'upto' micro-steps; fixw>=0 gives exactly that many wait cycles per memory step
    task automatic run_instr(input logic [31:0] instr, input int upto, input int fixw);
        int waits;
        build(instr);
        if (upto > steps.size()) upto = steps.size();
        for (int k = 0; k < upto; k++) begin
            waits = 0;
            forever begin
                @(negedge clk);
                clr = 0;
                ir = (k < 3) ? $urandom : instr;
                if (fixw >= 0) mem_rdy = !mem[k] || waits >= fixw;
                else mem_rdy = mem[k] ? (waits >= 5 || $urandom_range(99) >= 40) : 1'($urandom);
                #1 check($sformatf("op%0d_T%0d_w%0d", instr[31:27], k, waits), 64'(obs), 64'(steps[k]));
                if (!mem[k] || mem_rdy) break;
                waits++;
            end
        end
    endtask

    task automatic do_reset(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            clr = 1;
            mem_rdy = 1'($urandom);
            ir = $urandom;
            #1 check("reset", 64'(obs), 64'd0);
        end
    endtask

    function automatic bit is_legal(input logic [4:0] op);
        return op <= 5'd8 || op == 5'd12 || op == 5'd15 || op == 5'd16 || op == 5'd20 ||
               op == 5'd22 || op == 5'd24 || op == 5'd25 || op == 5'd26 || op == 5'd27;
    endfunction

    initial begin
        logic [4:0] ops[17] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 12, 15, 16, 20, 22, 24, 25, 26};
        logic [4:0] op;
        do_reset(3);
        run_instr(32'h18A30000, 8, 0);
        run_instr({5'd0, 27'($urandom)}, 8, 3);
        run_instr({5'd2, 4'd3, 23'($urandom)}, 8, -1);
        run_instr({5'd15, 4'd2, 4'd5, 19'($urandom)}, 8, 0);
        run_instr({5'd31, 27'($urandom)}, 8, -1);
        for (int n = 0; n < 60; n++) begin
            op = ops[$urandom_range(16)];
            if ($urandom_range(9) == 0)
                for (int t = 0; t < 64 && is_legal(op); t++) op = 5'($urandom);
            run_instr({op, 27'($urandom)}, 8, -1);
        end
        run_instr({5'd2, 27'($urandom)}, 7, -1);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            mem_rdy = 0;
            #1 check("st_wait", 64'(obs), 64'(steps[7]));
        end
        @(negedge clk);
        clr = 1;
        mem_rdy = 1;
        #1 check("clr_in_wait", 64'(obs), 64'd0);
        run_instr({5'd6, 27'($urandom)}, 8, -1);
        run_instr({5'd27, 27'($urandom)}, 8, -1);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            mem_rdy = 1'($urandom);
            ir = $urandom;
            #1 check("halted", 64'(obs), 64'd0);
        end
        do_reset(1);
        run_instr({5'd12, 27'($urandom)}, 8, -1);
        run_instr({5'd16, 27'($urandom)}, 8, -1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
